mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single fixed-latency memory port.
// Data side normally wins; instruction fetch wins once it has waited
// STARVE_LIMIT cycles. One access in flight at a time: IDLE -> BUSY -> DONE.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_write_en,
  input  logic [31:0] mem_data_out,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE   = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        grant_i;
  logic        grant_d;

  // Grant decision, only meaningful in IDLE; starved fetch overrides data.
  always_comb begin
    grant_i = (state == IDLE) && i_req && (!d_req || (wait_cnt == STARVE));
    grant_d = (state == IDLE) && d_req && !grant_i;
  end

  // Memory address/data come straight from the request latched at grant.
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;

  // Main FSM with registered strobes, acks and read-data capture.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner        <= 1'b0;
      busy         <= 1'b0;
      mem_write_en <= 1'b0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      mem_write_en <= 1'b0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state        <= BUSY;
            busy         <= 1'b1;
            cnt          <= CNT_INIT;
            owner        <= grant_i;
            addr_q       <= grant_i ? i_addr : d_addr;
            wdata_q      <= d_wdata;
            // Fetches never write, whatever d_we happens to be.
            we_q         <= grant_d && d_we;
            mem_write_en <= grant_d && d_we;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (!we_q) begin
              if (owner) i_rdata <= mem_data_out;
              else       d_rdata <= mem_data_out;
            end
            i_ack <= owner;
            d_ack <= !owner;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch wait counter: counts every cycle a pending fetch is passed over.
  always_ff @(posedge clk) begin
    if (rst_b)
      wait_cnt <= '0;
    else if (!i_req || grant_i)
      wait_cnt <= '0;
    else if (wait_cnt != STARVE)
      wait_cnt <= wait_cnt + 4'd1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences,
// then random traffic against a transaction-level timing/scoreboard model.
module tb_mem_port_arbiter;
  localparam int L  = 4;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_write_en;
  logic [31:0] mem_data_out = '0;
  logic        busy;
  logic        owner;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back as addr ^ 0xC0DE0000.
  logic [31:0] tb_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  always @(posedge clk) if (mem_write_en) tb_mem[mem_addr] = mem_data_in;
  always @(negedge clk) mem_data_out = mem_rd(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_i;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[7];

  // One complete access; hold keeps req high through the DONE cycle.
  task automatic run_one(input vec_t v, input bit hold);
    int n, wen, extra;
    bit seen, addr_ok;
    logic [31:0] d_before;
    d_before = d_rdata; n = 0; wen = 0; seen = 0; addr_ok = 1; extra = 0;
    if (v.is_i) begin i_req = 1; i_addr = v.addr; end
    else begin d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
    while (!seen && n < 40) begin
      step(); n++;
      if (busy && mem_addr !== v.addr) addr_ok = 0;
      if (mem_write_en) begin wen++; chk("write data", mem_data_in, v.wdata); end
      if (i_ack || d_ack) begin
        seen = 1;
        chk("ack port", {i_ack, d_ack}, {v.is_i, !v.is_i});
        if (v.is_i) chk("i_rdata", i_rdata, v.exp_rd);
        else if (v.we) chk("d_rdata kept on write", d_rdata, d_before);
        else chk("d_rdata", d_rdata, v.exp_rd);
        if (!hold) begin i_req = 0; d_req = 0; end
      end
    end
    chk("ack latency", n, L + 1);
    chk("write strobe cycles", wen, (v.we && !v.is_i) ? 1 : 0);
    chk("mem_addr held", addr_ok, 1);
    step();
    if (hold) begin
      i_req = 0; d_req = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (i_ack || d_ack || busy) extra++;
      end
      chk("held req regrant", extra, 0);
    end
  endtask

  // Random-phase model state.
  int grant_cyc, ack_cyc, idle_at, wait_m;
  bit port_m, owner_m, we_m, gi, gd;
  logic [31:0] addr_m, wd_m, rd_m, ei_rd, ed_rd;

  initial begin
    int n, dacks, iack_n, extra;
    bit d_rearm, d_seen, i_seen;
    int dn, in_;

    vt[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1'b0, 1'b1, 32'h40,  32'h12345678, 32'h0};
    vt[2] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h12345678};
    vt[3] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h12345678};
    vt[4] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'hC0DE0200};
    vt[5] = '{1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0};
    vt[6] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hA5A5A5A5};
    tb_mem[32'h100] = 32'hDEADBEEF;

    // Reset state
    #1; step(); step();
    chk("reset acks", {i_ack, d_ack}, 0);
    chk("reset busy/owner/wen", {busy, owner, mem_write_en}, 0);
    chk("reset i_rdata", i_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_data_in", mem_data_in, 0);
    rst_b = 0;
    step();

    // Directed vector table
    for (int k = 0; k < 7; k++) run_one(vt[k], 1'b0);

    // Simultaneous requests: data first, fetch at the next IDLE
    i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h304;
    n = 0; dn = -1; in_ = -1; d_seen = 0; i_seen = 0;
    step(); n++;
    chk("simul first owner", owner, 0);
    while (!i_seen && n < 40) begin
      if (d_ack) begin d_seen = 1; dn = n; d_req = 0; end
      if (i_ack) begin i_seen = 1; in_ = n; i_req = 0; end
      if (!i_seen) begin step(); n++; end
    end
    chk("simul d_ack cycle", dn, L + 1);
    chk("simul i_ack cycle", in_, 2 * L + 3);
    chk("simul d_rdata", d_rdata, 32'hC0DE0304);
    chk("simul i_rdata", i_rdata, 32'hC0DE0300);
    step();

    // Starvation: continuous data stream with a fetch held pending
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
    n = 0; dacks = 0; iack_n = -1; d_rearm = 0;
    while (iack_n < 0 && n < 100) begin
      step(); n++;
      if (d_rearm) begin d_req = 1; d_rearm = 0; end
      if (d_ack) begin dacks++; d_req = 0; d_rearm = 1; end
      if (i_ack) begin iack_n = n; i_req = 0; d_req = 0; d_rearm = 0; end
    end
    chk("starve data count", dacks, 2);
    chk("starve i_ack cycle", iack_n, 2 * (L + 2) + L + 1);
    step(); step();

    // Reset two cycles into a data write
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hAAAA5555;
    step(); step();
    rst_b = 1;
    step();
    chk("abort busy/wen/ack", {busy, mem_write_en, d_ack, i_ack}, 0);
    chk("abort d_rdata", d_rdata, 0);
    rst_b = 0; d_req = 0; d_we = 0; extra = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (d_ack || i_ack || busy) extra++;
    end
    chk("abort no ack", extra, 0);
    run_one(vt[4], 1'b0);

    // Requester holding d_req into DONE
    run_one('{1'b0, 1'b0, 32'h44, 32'h0, 32'hC0DE0044}, 1'b1);

    // Random traffic against the timing/scoreboard model
    rst_b = 1; step();
    rst_b = 0; i_req = 0; d_req = 0;
    ref_mem = tb_mem;
    grant_cyc = -100; ack_cyc = -1; idle_at = 0; wait_m = 0;
    port_m = 0; owner_m = 0; we_m = 0; addr_m = 0; wd_m = 0; rd_m = 0;
    ei_rd = 0; ed_rd = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) step();
      if (c == ack_cyc && !we_m) begin
        if (port_m) ei_rd = rd_m; else ed_rd = rd_m;
      end
      chk("rnd acks", {i_ack, d_ack}, {c == ack_cyc && port_m, c == ack_cyc && !port_m});
      chk("rnd busy", busy, (c > grant_cyc && c < idle_at));
      chk("rnd write strobe", mem_write_en, (c == grant_cyc + 1 && we_m));
      if (c == grant_cyc + 1 && we_m) chk("rnd write data", mem_data_in, wd_m);
      if (c > grant_cyc && c < idle_at) chk("rnd mem_addr", mem_addr, addr_m);
      chk("rnd owner", owner, owner_m);
      chk("rnd i_rdata", i_rdata, ei_rd);
      chk("rnd d_rdata", d_rdata, ed_rd);
      // requesters
      if (i_ack) i_req = 0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = 32'($urandom_range(0, 7));
      end
      if (d_ack) d_req = 0;
      else if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 7)); d_wdata = $urandom;
      end
      // disturb inputs of the access already in flight
      if (c > grant_cyc && c < idle_at) begin
        if (port_m && i_req && !i_ack) i_addr = $urandom;
        if (!port_m && d_req && !d_ack) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        end
      end
      // arbitration rules
      gi = 0; gd = 0;
      if (c >= idle_at) begin
        gi = i_req && (!d_req || wait_m == SL);
        gd = d_req && !gi;
      end
      if (gi || gd) begin
        grant_cyc = c; ack_cyc = c + L + 1; idle_at = c + L + 2;
        port_m = gi; owner_m = gi; we_m = gd && d_we;
        addr_m = gi ? i_addr : d_addr; wd_m = d_wdata;
        if (we_m) ref_mem[addr_m] = wd_m;
        else rd_m = ref_mem.exists(addr_m) ? ref_mem[addr_m] : (addr_m ^ 32'hC0DE_0000);
      end
      if (i_req && !gi) wait_m = (wait_m < SL) ? wait_m + 1 : SL;
      else wait_m = 0;
    end
    i_req = 0; d_req = 0;
    for (int k = 0; k < 20 && busy; k++) step();
    step();
    chk("drain idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
